// File: rtl/predictor_update_scheduler.sv
// Funnels the ID and EX predictor update ports onto the single table write port
// through a small FIFO, with same-key coalescing and a full-table clear sweep.
module predictor_update_scheduler #(
  parameter int ADDR_WIDTH  = 3,
  parameter int INDEX_WIDTH = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req1_valid,
  input  logic                   req1_clr,
  input  logic [ADDR_WIDTH-1:0]  req1_addr,
  input  logic [INDEX_WIDTH-1:0] req1_index,
  input  logic [DATA_WIDTH-1:0]  req1_data,
  input  logic                   req2_valid,
  input  logic                   req2_clr,
  input  logic [ADDR_WIDTH-1:0]  req2_addr,
  input  logic [INDEX_WIDTH-1:0] req2_index,
  input  logic [DATA_WIDTH-1:0]  req2_data,
  input  logic                   clear_all,
  output logic                   stall_req,
  output logic                   tbl_we,
  output logic                   tbl_clr,
  output logic [ADDR_WIDTH-1:0]  tbl_addr,
  output logic [INDEX_WIDTH-1:0] tbl_index,
  output logic [DATA_WIDTH-1:0]  tbl_data,
  output logic                   busy,
  output logic [7:0]             drop_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = 1 + ADDR_WIDTH + INDEX_WIDTH + DATA_WIDTH;

  // state    | meaning
  // ST_RUN   | drain one FIFO entry per cycle onto the table port
  // ST_SWEEP | clear every table address in turn; FIFO only fills
  typedef enum logic {ST_RUN, ST_SWEEP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [EW-1:0]          r_fifo [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr, w_wr_ptr1;
  logic [CW-1:0]          r_count, w_free;
  logic [ADDR_WIDTH-1:0]  r_sweep_addr;
  logic                   w_flush, w_coalesce, w_cand2, w_cand1;
  logic                   w_acc2, w_acc1, w_pop, w_sweep_last;
  logic [1:0]             w_drops;
  logic [8:0]             w_drop_sum;
  logic [EW-1:0]          w_ent1, w_ent2, w_head;
  logic                   r_tbl_we, r_tbl_clr;
  logic [ADDR_WIDTH-1:0]  r_tbl_addr;
  logic [INDEX_WIDTH-1:0] r_tbl_index;
  logic [DATA_WIDTH-1:0]  r_tbl_data;
  logic [7:0]             r_drop_count;

  assign w_free       = CW'(FIFO_DEPTH) - r_count;
  assign w_flush      = (r_state == ST_RUN) && clear_all;
  // Port 1 is the younger update for the same counter, so it supersedes port 2.
  assign w_coalesce   = req1_valid && req2_valid && !req1_clr && !req2_clr &&
                        (req1_addr == req2_addr) && (req1_index == req2_index);
  assign w_cand2      = req2_valid && !w_coalesce && !w_flush;
  assign w_cand1      = req1_valid && !w_flush;
  assign w_acc2       = w_cand2 && (w_free != '0);
  assign w_acc1       = w_cand1 && (w_free > (w_cand2 ? CW'(1) : CW'(0)));
  assign w_drops      = 2'(w_cand2 && !w_acc2) + 2'(w_cand1 && !w_acc1);
  assign w_drop_sum   = {1'b0, r_drop_count} + 9'(w_drops);
  assign w_pop        = (r_state == ST_RUN) && !clear_all && (r_count != '0);
  assign w_wr_ptr1    = r_wr_ptr + PW'(w_acc2);
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_sweep_last = &r_sweep_addr;
  assign w_ent2       = {req2_clr, req2_addr, req2_index, req2_data};
  assign w_ent1       = {req1_clr, req1_addr, req1_index, req1_data};

  always_ff @(posedge clk) begin
    if (w_acc2) r_fifo[r_wr_ptr] <= w_ent2;
    if (w_acc1) r_fifo[w_wr_ptr1] <= w_ent1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (clear_all)    w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (w_sweep_last) w_state_nxt = ST_RUN;
      default:                    w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_sweep_addr <= '0;
      r_tbl_we     <= 1'b0;
      r_tbl_clr    <= 1'b0;
      r_tbl_addr   <= '0;
      r_tbl_index  <= '0;
      r_tbl_data   <= '0;
      r_drop_count <= '0;
    end else begin
      r_tbl_we  <= 1'b0;
      r_tbl_clr <= 1'b0;
      if (w_flush) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_sweep_addr <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + PW'(w_acc2) + PW'(w_acc1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count  <= r_count + CW'(w_acc2) + CW'(w_acc1) - CW'(w_pop);
      end
      if (r_state == ST_SWEEP) begin
        r_tbl_clr    <= 1'b1;
        r_tbl_addr   <= r_sweep_addr;
        r_sweep_addr <= r_sweep_addr + ADDR_WIDTH'(1);
      end else if (w_pop) begin
        r_tbl_we  <= !w_head[EW-1];
        r_tbl_clr <= w_head[EW-1];
        {r_tbl_addr, r_tbl_index, r_tbl_data} <= w_head[EW-2:0];
      end
      r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign stall_req  = (w_free < CW'(2));
  assign busy       = (r_count != '0) || (r_state == ST_SWEEP) || r_tbl_we || r_tbl_clr;
  assign tbl_we     = r_tbl_we;
  assign tbl_clr    = r_tbl_clr;
  assign tbl_addr   = r_tbl_addr;
  assign tbl_index  = r_tbl_index;
  assign tbl_data   = r_tbl_data;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_predictor_update_scheduler.sv
// Bench for predictor_update_scheduler: queue-based reference model checked every
// cycle, plus table vectors and hand sequences for overflow, sweep and reset.
module tb_predictor_update_scheduler;
  localparam int AW = 3, IW = 2, DW = 16, DEPTH = 4, NADDR = 1 << AW;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req1_valid, req1_clr, req2_valid, req2_clr, clear_all;
  logic [AW-1:0] req1_addr, req2_addr;
  logic [IW-1:0] req1_index, req2_index;
  logic [DW-1:0] req1_data, req2_data;
  logic stall_req, tbl_we, tbl_clr, busy;
  logic [AW-1:0] tbl_addr;
  logic [IW-1:0] tbl_index;
  logic [DW-1:0] tbl_data;
  logic [7:0] drop_count;

  predictor_update_scheduler #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .DATA_WIDTH(DW),
                               .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req1_valid(req1_valid), .req1_clr(req1_clr), .req1_addr(req1_addr),
    .req1_index(req1_index), .req1_data(req1_data),
    .req2_valid(req2_valid), .req2_clr(req2_clr), .req2_addr(req2_addr),
    .req2_index(req2_index), .req2_data(req2_data),
    .clear_all(clear_all), .stall_req(stall_req), .tbl_we(tbl_we), .tbl_clr(tbl_clr),
    .tbl_addr(tbl_addr), .tbl_index(tbl_index), .tbl_data(tbl_data),
    .busy(busy), .drop_count(drop_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic          clr;
    logic [AW-1:0] addr;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    int v2, c2, a2, i2, d2;
    int v1, c1, a1, i1, d1;
    int n, ec0, ea0, ed0, ec1, ea1, ed1;
  } vec_t;

  ent_t mq[$];
  ent_t obs[$];
  int m_sweep_left, m_drops;
  bit m_we, m_clr;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_idx;
  logic [DW-1:0] m_data;
  int total = 0, bad = 0;
  vec_t tv[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of pending entries and a count of sweep clears still owed.
  task automatic model_step();
    int free;
    ent_t c[$];
    ent_t e;
    if (!rst_n) begin
      mq.delete(); m_sweep_left = 0; m_drops = 0;
      m_we = 0; m_clr = 0; m_addr = '0; m_idx = '0; m_data = '0;
      return;
    end
    free = DEPTH - mq.size();
    m_we = 0; m_clr = 0;
    if (m_sweep_left == 0 && clear_all) begin
      mq.delete();
      m_sweep_left = NADDR;
      return;
    end
    if (m_sweep_left > 0) begin
      m_clr = 1; m_addr = AW'(NADDR - m_sweep_left); m_sweep_left--;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = !e.clr; m_clr = e.clr; m_addr = e.addr; m_idx = e.idx; m_data = e.data;
    end
    if (req2_valid && !(req1_valid && !req1_clr && !req2_clr &&
        req1_addr == req2_addr && req1_index == req2_index))
      c.push_back('{req2_clr, req2_addr, req2_index, req2_data});
    if (req1_valid) c.push_back('{req1_clr, req1_addr, req1_index, req1_data});
    foreach (c[k]) begin
      if (free > 0) begin mq.push_back(c[k]); free--; end
      else if (m_drops < 255) m_drops++;
    end
  endtask

  task automatic check_outputs();
    int fr;
    fr = DEPTH - mq.size();
    chk("tbl_we", tbl_we, m_we);
    chk("tbl_clr", tbl_clr, m_clr);
    chk("tbl_addr", tbl_addr, m_addr);
    chk("tbl_index", tbl_index, m_idx);
    chk("tbl_data", tbl_data, m_data);
    chk("stall_req", stall_req, fr < 2);
    chk("busy", busy, (mq.size() != 0) || (m_sweep_left > 0) || m_we || m_clr);
    chk("drop_count", drop_count, m_drops);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    if (tbl_we || tbl_clr) obs.push_back('{tbl_clr, tbl_addr, tbl_index, tbl_data});
  endtask

  task automatic set2(int v, int c, int a, int i, int d);
    req2_valid = v[0]; req2_clr = c[0]; req2_addr = AW'(a); req2_index = IW'(i); req2_data = DW'(d);
  endtask

  task automatic set1(int v, int c, int a, int i, int d);
    req1_valid = v[0]; req1_clr = c[0]; req1_addr = AW'(a); req1_index = IW'(i); req1_data = DW'(d);
  endtask

  task automatic idle();
    set2(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); clear_all = 0;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; step(); rst_n = 1;
  endtask

  initial begin
    //           v2 c2 a2 i2 d2        v1 c1 a1 i1 d1        n ec0 ea0 ed0      ec1 ea1 ed1
    tv[0] = '{1, 0, 5, 2, 'h00A3, 0, 0, 0, 0, 0,      1, 0, 5, 'h00A3, 0, 0, 0};
    tv[1] = '{1, 0, 3, 1, 'h0022, 1, 0, 3, 1, 'h0011, 1, 0, 3, 'h0011, 0, 0, 0};
    tv[2] = '{1, 0, 1, 0, 'h0101, 1, 0, 2, 0, 'h0202, 2, 0, 1, 'h0101, 0, 2, 'h0202};
    tv[3] = '{1, 0, 6, 0, 'h1234, 1, 0, 6, 3, 'h5678, 2, 0, 6, 'h1234, 0, 6, 'h5678};
    tv[4] = '{1, 1, 7, 0, 0,      1, 1, 7, 0, 0,      2, 1, 7, 0,      1, 7, 0};
    tv[5] = '{1, 0, 4, 1, 'hBEEF, 1, 1, 4, 1, 0,      2, 0, 4, 'hBEEF, 1, 4, 0};
    tv[6] = '{0, 0, 0, 0, 0,      1, 0, 0, 3, 'hFFFF, 1, 0, 0, 'hFFFF, 0, 0, 0};
    tv[7] = '{0, 0, 0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0};

    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall_req, 0);

    foreach (tv[k]) begin
      obs.delete();
      set2(tv[k].v2, tv[k].c2, tv[k].a2, tv[k].i2, tv[k].d2);
      set1(tv[k].v1, tv[k].c1, tv[k].a1, tv[k].i1, tv[k].d1);
      step();
      idle();
      repeat (4) step();
      chk("vec_nstrobe", obs.size(), tv[k].n);
      if (obs.size() > 0 && tv[k].n > 0) begin
        chk("vec_clr0", obs[0].clr, tv[k].ec0);
        chk("vec_addr0", obs[0].addr, tv[k].ea0);
        if (tv[k].ec0 == 0) chk("vec_data0", obs[0].data, tv[k].ed0);
      end
      if (obs.size() > 1 && tv[k].n > 1) begin
        chk("vec_clr1", obs[1].clr, tv[k].ec1);
        chk("vec_addr1", obs[1].addr, tv[k].ea1);
        if (tv[k].ec1 == 0) chk("vec_data1", obs[1].data, tv[k].ed1);
      end
      chk("vec_drops", drop_count, 0);
    end

    // Overflow: the cycle-1 pop frees a slot before cycle 2's space check, so five fit.
    do_reset();
    obs.delete();
    set2(1, 0, 1, 0, 'h10); set1(1, 0, 2, 0, 'h20); step();
    chk("ovf_stall_c0", stall_req, 0);
    set2(1, 0, 3, 0, 'h30); set1(1, 0, 4, 0, 'h40); step();
    chk("ovf_stall_c1", stall_req, 1);
    set2(1, 0, 5, 0, 'h50); set1(1, 0, 6, 0, 'h60); step();
    idle();
    repeat (6) step();
    chk("ovf_drops", drop_count, 1);
    chk("ovf_nstrobe", obs.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < obs.size()) chk("ovf_order", obs[k].addr, k + 1);

    // clear_all with three entries queued.
    do_reset();
    set2(1, 0, 1, 0, 'hA1); set1(1, 0, 2, 0, 'hA2); step();
    set2(1, 0, 3, 0, 'hA3); set1(1, 0, 4, 0, 'hA4); step();
    idle();
    clear_all = 1; step();
    clear_all = 0;
    chk("clr_no_we", tbl_we, 0);
    chk("clr_busy", busy, 1);
    for (int k = 0; k < NADDR; k++) begin
      if (k == 3) set2(1, 0, 5, 1, 'hC0DE);
      step();
      idle();
      chk("sweep_clr", tbl_clr, 1);
      chk("sweep_we", tbl_we, 0);
      chk("sweep_addr", tbl_addr, k);
    end
    step();
    chk("post_sweep_we", tbl_we, 1);
    chk("post_sweep_addr", tbl_addr, 5);
    chk("post_sweep_data", tbl_data, 'hC0DE);
    repeat (3) step();

    // Hammer requests during sweeps until drop_count saturates.
    for (int it = 0; it < 20; it++) begin
      idle(); clear_all = 1; step(); clear_all = 0;
      for (int k = 0; k < 9; k++) begin
        set2(1, 0, k % NADDR, 0, it); set1(1, 0, (k + 1) % NADDR, 0, k);
        step();
      end
    end
    chk("drop_saturated", drop_count, 255);

    // Reset in the middle of a sweep.
    idle(); repeat (6) step();
    clear_all = 1; step(); clear_all = 0;
    for (int k = 0; k < 5; k++) step();
    chk("mid_sweep_addr", tbl_addr, 4);
    rst_n = 0; step(); rst_n = 1;
    chk("rst_tbl_clr", tbl_clr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drops", drop_count, 0);
    obs.delete();
    repeat (10) step();
    chk("rst_no_strobes", obs.size(), 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      set2($urandom_range(0, 1), ($urandom_range(0, 7) == 0), $urandom_range(0, NADDR - 1),
           $urandom_range(0, 3), $urandom_range(0, 65535));
      set1($urandom_range(0, 1), ($urandom_range(0, 7) == 0), $urandom_range(0, NADDR - 1),
           $urandom_range(0, 3), $urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) begin req1_addr = req2_addr; req1_index = req2_index; end
      clear_all = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      step();
    end
    idle(); rst_n = 1;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
